// File: rtl/apb_pkg.sv
// Shared APB slave definitions.
// Holds the slave FSM state encoding, the byte-to-word address shift,
// and the default APB address width.
package apb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    W_ACC,
    R_WAIT,
    R_ACC,
    E_ACC
  } state_t;

  localparam int unsigned BYTE_SHIFT          = 2;
  localparam int unsigned DEFAULT_PADDR_WIDTH = 32;

endpackage

// File: rtl/apb_rf_slave_if.sv
// APB3 bus bundle between an APB master/interconnect and a slave.
// Signals:
//   psel, penable, pwrite, paddr, pwdata : master -> slave
//   prdata, pready, pslverr               : slave -> master
interface apb_rf_slave_if #(
  parameter int unsigned data_width  = 32,
  parameter int unsigned paddr_width = 32
) ();

  logic                   psel;
  logic                   penable;
  logic                   pwrite;
  logic [paddr_width-1:0] paddr;
  logic [data_width-1:0]  pwdata;
  logic [data_width-1:0]  prdata;
  logic                   pready;
  logic                   pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_rf_slave.sv
// APB3 slave front-end for port 1 of a register file.
// Decodes word addresses, adds the single wait state that the file's
// registered read requires, and answers illegal addresses with PSLVERR.
// Ports:
//   clk       rising-edge clock
//   reset_n   synchronous reset, active-low
//   apb       APB3 slave bundle (psel/penable/pwrite/paddr/pwdata in,
//             prdata/pready/pslverr out)
//   rf_wr     register-file write enable (high = write)
//   rf_addr   register index
//   rf_wdata  register-file write data
//   rf_rdata  register-file registered read data
module apb_rf_slave
  import apb_pkg::*;
#(
  parameter int unsigned data_width  = 32,
  parameter int unsigned addr_width  = 4,
  parameter int unsigned paddr_width = DEFAULT_PADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  apb_rf_slave_if.slave         apb,
  output logic                  rf_wr,
  output logic [addr_width-1:0] rf_addr,
  output logic [data_width-1:0] rf_wdata,
  input  logic [data_width-1:0] rf_rdata
);

  state_t                state;
  logic                  setup;
  logic                  legal;
  logic [addr_width-1:0] index;

  assign setup = apb.psel && !apb.penable;
  assign index = apb.paddr[addr_width+BYTE_SHIFT-1:BYTE_SHIFT];
  assign legal = (apb.paddr[BYTE_SHIFT-1:0] == '0) &&
                 (apb.paddr[paddr_width-1:addr_width+BYTE_SHIFT] == '0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      rf_wr    <= 1'b0;
      rf_addr  <= '0;
      rf_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (setup) begin
            rf_addr  <= index;
            rf_wdata <= apb.pwdata;
            if (!legal) begin
              state <= E_ACC;
            end else if (apb.pwrite) begin
              state <= W_ACC;
              rf_wr <= 1'b1;
            end else begin
              state <= R_WAIT;
              rf_wr <= 1'b0;
            end
          end
        end
        // The file commits at the edge leaving W_ACC, so an abort here
        // still lets the write land.
        W_ACC: begin
          rf_wr <= 1'b0;
          state <= IDLE;
        end
        // The file captures rf[rf_addr] at this edge; abandon if the
        // master has dropped psel.
        R_WAIT:  state <= apb.psel ? R_ACC : IDLE;
        R_ACC:   state <= IDLE;
        E_ACC:   state <= IDLE;
        default: begin
          state <= IDLE;
          rf_wr <= 1'b0;
        end
      endcase
    end
  end

  assign apb.pready  = (state == W_ACC) || (state == R_ACC) || (state == E_ACC);
  assign apb.pslverr = (state == E_ACC);
  assign apb.prdata  = (state == R_ACC) ? rf_rdata : '0;

endmodule

// File: tb/tb_apb_rf_slave.sv
module tb_apb_rf_slave;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;
  localparam int unsigned PW = 32;

  logic          clk;
  logic          reset_n;
  logic          rf_wr;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_wdata;
  logic [DW-1:0] rf_rdata;

  apb_rf_slave_if #(.data_width(DW), .paddr_width(PW)) bus ();

  apb_rf_slave #(.data_width(DW), .addr_width(AW), .paddr_width(PW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .apb      (bus.slave),
    .rf_wr    (rf_wr),
    .rf_addr  (rf_addr),
    .rf_wdata (rf_wdata),
    .rf_rdata (rf_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register-file storage behind port 1: write on rf_wr, registered read.
  logic [DW-1:0] rf_mem [16];
  always @(posedge clk) begin
    if (rf_wr) rf_mem[rf_addr] <= rf_wdata;
    rf_rdata <= rf_mem[rf_addr];
  end

  // Reference model: ideal APB-visible register contents.
  logic [DW-1:0] mdl [16];

  typedef struct {
    int          kind;   // 0 write, 1 read, 2 error
    int          idx;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit addr_legal(input logic [31:0] a);
    return (a % 4 == 0) && (a < 64);
  endfunction

  task automatic idle();
    @(posedge clk); #1;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
  endtask

  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                      input bit abort);
    exp_t e;
    int   lat;
    int   cycles;
    bit   done;
    e.idx  = int'(addr / 4) % 16;
    e.data = '0;
    if (!addr_legal(addr)) begin
      e.kind = 2;
      lat    = 1;
    end else if (wr) begin
      e.kind = 0;
      e.data = data;
      lat    = 1;
    end else begin
      e.kind = 1;
      e.data = mdl[e.idx];
      lat    = 2;
    end
    if (!abort) begin
      if (e.kind == 0) mdl[e.idx] = data;
      q.push_back(e);
    end
    @(posedge clk); #1;
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = wr;
    bus.paddr   = addr;
    bus.pwdata  = data;
    @(posedge clk); #1;
    if (abort) begin
      bus.psel    = 1'b0;
      bus.penable = 1'b0;
      @(negedge clk);
      check("abort_wait_pready", {31'b0, bus.pready}, 32'd0);
      @(negedge clk);
      check("abort_idle_pready", {31'b0, bus.pready}, 32'd0);
      check("abort_idle_pslverr", {31'b0, bus.pslverr}, 32'd0);
      return;
    end
    bus.penable = 1'b1;
    cycles = 0;
    done   = 1'b0;
    while (!done && cycles < 8) begin
      @(negedge clk);
      cycles++;
      if (bus.pready) done = 1'b1;
    end
    check("access_cycles", cycles, lat);
  endtask

  // Monitor: every completed access pops one expected response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && bus.pready) begin
        if (!(bus.psel && bus.penable)) begin
          check("pready_outside_access", {31'b0, bus.psel && bus.penable}, 32'd1);
        end else if (q.size() == 0) begin
          check("scoreboard_underflow", q.size(), 32'd1);
        end else begin
          e = q.pop_front();
          check("pslverr", {31'b0, bus.pslverr}, (e.kind == 2) ? 32'd1 : 32'd0);
          check("prdata", bus.prdata, (e.kind == 1) ? e.data : 32'd0);
          check("rf_wr", {31'b0, rf_wr}, (e.kind == 0) ? 32'd1 : 32'd0);
          if (e.kind == 0) begin
            check("rf_addr", {28'b0, rf_addr}, e.idx);
            check("rf_wdata", rf_wdata, e.data);
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] a;
    int          r;
    for (int i = 0; i < 16; i++) begin
      rf_mem[i] = '0;
      mdl[i]    = '0;
    end
    reset_n     = 1'b0;
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b1;
    bus.paddr   = 32'h0C;
    bus.pwdata  = 32'hFFFF_FFFF;

    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("reset_pready", {31'b0, bus.pready}, 32'd0);
      check("reset_pslverr", {31'b0, bus.pslverr}, 32'd0);
      check("reset_prdata", bus.prdata, 32'd0);
      check("reset_rf_wr", {31'b0, rf_wr}, 32'd0);
    end
    check("reset_rf_addr", {28'b0, rf_addr}, 32'd0);
    check("reset_rf_wdata", rf_wdata, 32'd0);
    @(posedge clk); #1;
    reset_n  = 1'b1;
    bus.psel = 1'b0;
    @(negedge clk);
    check("post_reset_pready", {31'b0, bus.pready}, 32'd0);
    check("post_reset_rf_wr", {31'b0, rf_wr}, 32'd0);
    mon_en = 1'b1;

    // Directed write/read, illegal addresses, index 0 untouched.
    xfer(1'b1, 32'h0C, 32'hDEAD_BEEF, 1'b0);
    idle();
    xfer(1'b0, 32'h0C, 32'h0, 1'b0);
    idle();
    xfer(1'b1, 32'h40, 32'hBAD0_0001, 1'b0);
    xfer(1'b1, 32'h06, 32'hBAD0_0002, 1'b0);
    xfer(1'b0, 32'h00, 32'h0, 1'b0);
    idle();

    // Back-to-back, no idle cycles.
    xfer(1'b1, 32'h00, 32'h11, 1'b0);
    xfer(1'b0, 32'h00, 32'h0, 1'b0);
    xfer(1'b1, 32'h3C, 32'h22, 1'b0);
    xfer(1'b0, 32'h3C, 32'h0, 1'b0);
    idle();

    // Abort in the read wait state, then a normal write and readback.
    xfer(1'b0, 32'h04, 32'h0, 1'b1);
    xfer(1'b1, 32'h08, 32'h3333_4444, 1'b0);
    xfer(1'b0, 32'h08, 32'h0, 1'b0);
    idle();

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7)       a = {26'b0, 4'($urandom_range(0, 15)), 2'b00};
      else if (r == 7) a = {26'b0, 4'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
      else if (r == 8) a = 32'h1 << $urandom_range(6, 31);
      else             a = $urandom;
      xfer(1'($urandom_range(0, 1)), a, $urandom, 1'b0);
      if ($urandom_range(0, 2) == 0) idle();
    end
    idle();

    for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drain", q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
